add_sub32: RTL and testbench
============================

// Module: add_sub32
// PURPOSE
//   32-bit two's-complement adder/subtractor with carry-out and signed-overflow flags.
//   Serves as the integer add/sub datapath element for ALU-style consumers.
//   Inputs are captured combinationally and the result is registered.
//   Fixed latency is one clk cycle.
// PARAMETERS
//   WIDTH  32  operand/result width; must be a multiple of 4 (CLA group size)
// PORTS
//   clk   in   1      clock; all state updates on rising edge
//   rst   in   1      asynchronous, active-high reset
//   A     in   WIDTH  operand A
//   B     in   WIDTH  operand B
//   SUB   in   1      0: A+B; 1: A-B
//   ans   out  WIDTH  registered result
//   cout  out  1      registered carry-out of MSB
//   V     out  1      registered signed overflow
//   Z     out  1      registered zero flag (only when ADDSUB_ZERO_FLAG_EN defined)
// BEHAVIOUR
//   - One clock, clk. Reset is asynchronous and active-high (rst).
//   - rst=1 forces ans=0, cout=0 and V=0 (and Z=0) immediately, independent of clk.
//     Outputs hold these values while rst is asserted.
//   - Datapath: Beff = SUB ? ~B : B; cin = SUB.
//     {c_WIDTH, sum} = A + Beff + cin, computed modulo 2^WIDTH.
//   - cout = c_WIDTH. For subtract, cout=1 means no borrow (A >= B unsigned).
//   - V = c_WIDTH ^ c_(WIDTH-1).
//     Equivalently, the operand signs as seen by the adder match and the result sign differs.
//   - On each rising clk with rst=0, {ans,cout,V} register the combinational result of the A/B/SUB present at that edge.
//     Latency is 1 cycle. Throughput is one operation per cycle. No handshake.
//   - rst deasserted between edges: the first capture occurs at the next rising edge.
//   - An operation in flight when rst asserts is discarded, with no partial result.
//   - Wrap-around is silent; only cout and V report it.
//   - X on any input may propagate X to the outputs. No sanitising.
// CONFIGURATION
//   ADDSUB_ZERO_FLAG_EN
//   - Defined: adds port Z, registered with the other outputs. Z = (sum == 0). Reset value is 0.
//   - Undefined: port Z is absent; all other behaviour is identical.
// STRUCTURE
//   - Package add_sub32_pkg holds:
//     - localparam ADDSUB_W=32
//     - localparam CLA_GRP=4
//     - typedef addsub_res_t {logic [ADDSUB_W-1:0] sum; logic cout; logic v;}
//   - Sub-module cla4: 4-bit carry-lookahead group.
//     - Inputs: a[3:0], b[3:0], cin.
//     - Outputs: s[3:0], the carry into bit 3 (c3), and cout.
//   - Top: WIDTH/4 cla4 instances with the group carries rippled; B-invert XOR stage; output register.
//   - V is taken from the MSB group's c3 ^ cout.
// TESTING
//   - Reset: assert rst mid-cycle with nonzero outputs -> ans=0, cout=0, V=0 before the next edge.
//   - A=7FFFFFFF B=00000001 SUB=0 -> next cycle ans=80000000 cout=0 V=1.
//   - A=FFFFFFFF B=00000001 SUB=0 -> ans=00000000 cout=1 V=0 (Z=1 if enabled).
//   - A=00000003 B=00000005 SUB=1 -> ans=FFFFFFFE cout=0 V=0.
//   - A=80000000 B=00000001 SUB=1 -> ans=7FFFFFFF cout=1 V=1.
//     Then A=5 B=3 SUB=1 on the next cycle -> ans=2 cout=1 V=0, back-to-back with no bubble.
//   - 5000 random A/B/SUB vectors, one per cycle.
//     Compare against the behavioural model {cout,ans}=A+(SUB?~B:B)+SUB, with V from sign rules.
//     Check at 1-cycle latency; zero mismatches required.

Source files
------------

// File: rtl/add_sub32_pkg.sv
// rtl/add_sub32_pkg.sv - shared widths and result record for the add_sub32 datapath
package add_sub32_pkg;

  localparam int ADDSUB_W = 32;
  localparam int CLA_GRP  = 4;

  typedef struct packed {
    logic [ADDSUB_W-1:0] sum;
    logic                cout;
    logic                v;
  } addsub_res_t;

endpackage

// File: rtl/add_sub32_if.sv
// rtl/add_sub32_if.sv - operand/result bundle for add_sub32; Z exists only with ADDSUB_ZERO_FLAG_EN
interface add_sub32_if
  import add_sub32_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) ();

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic [WIDTH-1:0] ans;
  logic             cout;
  logic             V;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic             Z;
`endif

`ifdef ADDSUB_ZERO_FLAG_EN
  modport master (output A, B, SUB, input ans, cout, V, Z);
  modport slave  (input A, B, SUB, output ans, cout, V, Z);
`else
  modport master (output A, B, SUB, input ans, cout, V);
  modport slave  (input A, B, SUB, output ans, cout, V);
`endif

endinterface

// File: rtl/add_sub32_cla4.sv
// rtl/add_sub32_cla4.sv - 4-bit carry-lookahead group exposing the carry into bit 3 for overflow
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & cin);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s  = p ^ {c3, c2, c1, cin};
  end

endmodule

// File: rtl/add_sub32.sv
// rtl/add_sub32.sv - registered two's-complement add/sub with carry and overflow flags
// Optional zero flag output Z is built when ADDSUB_ZERO_FLAG_EN is defined.
module add_sub32
  import add_sub32_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic        clk,
  input  logic        rst,
  add_sub32_if.slave  bus
);

  // WIDTH must be a multiple of CLA_GRP; the group carries ripple between cla4 blocks.
  localparam int NGRP = WIDTH / CLA_GRP;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [NGRP:0]    grp_c;
  logic [NGRP-1:0]  grp_c3;

  logic [WIDTH-1:0] ans_d, ans_q;
  logic             cout_d, cout_q;
  logic             v_d, v_q;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic             z_d, z_q;
`endif

  assign b_eff    = bus.B ^ {WIDTH{bus.SUB}};
  assign grp_c[0] = bus.SUB;

  for (genvar g = 0; g < NGRP; g++) begin : g_cla
    cla4 u_cla4 (
      .a    (bus.A[g*CLA_GRP +: CLA_GRP]),
      .b    (b_eff[g*CLA_GRP +: CLA_GRP]),
      .cin  (grp_c[g]),
      .s    (sum[g*CLA_GRP +: CLA_GRP]),
      .c3   (grp_c3[g]),
      .cout (grp_c[g+1])
    );
  end

  always_comb begin
    ans_d  = sum;
    cout_d = grp_c[NGRP];
    v_d    = grp_c3[NGRP-1] ^ grp_c[NGRP];
`ifdef ADDSUB_ZERO_FLAG_EN
    z_d    = ~|sum;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ans_q  <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      z_q    <= 1'b0;
`endif
    end else begin
      ans_q  <= ans_d;
      cout_q <= cout_d;
      v_q    <= v_d;
`ifdef ADDSUB_ZERO_FLAG_EN
      z_q    <= z_d;
`endif
    end
  end

  assign bus.ans  = ans_q;
  assign bus.cout = cout_q;
  assign bus.V    = v_q;
`ifdef ADDSUB_ZERO_FLAG_EN
  assign bus.Z    = z_q;
`endif

endmodule

// File: tb/tb_add_sub32.sv
// tb/tb_add_sub32.sv - directed and random checks of add_sub32 at one-cycle latency
module tb_add_sub32;
  import add_sub32_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  add_sub32_if #(.WIDTH(ADDSUB_W)) bus ();

  add_sub32 #(.WIDTH(ADDSUB_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.A   = a;
    bus.B   = b;
    bus.SUB = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(32'h0000_0001, 32'h0000_0001, 1'b0);
    #1;
    n_checks++;
    if (bus.ans !== 32'h0 || bus.cout !== 1'b0 || bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: ans=%h cout=%b V=%b want 00000000 0 0", bus.ans, bus.cout, bus.V);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ans !== 32'h0 || bus.cout !== 1'b0 || bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ans=%h cout=%b V=%b want 00000000 0 0", bus.ans, bus.cout, bus.V);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.ans !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release_no_capture: ans=%h want 00000000", bus.ans);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ans !== 32'h2 || bus.cout !== 1'b0 || bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_capture: ans=%h cout=%b V=%b want 00000002 0 0", bus.ans, bus.cout, bus.V);
    end
    @(negedge clk);
    drive(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ans !== 32'h7FFF_FFFF || bus.cout !== 1'b1 || bus.V !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preload: ans=%h cout=%b V=%b want 7fffffff 1 1", bus.ans, bus.cout, bus.V);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ans !== 32'h0 || bus.cout !== 1'b0 || bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_midcycle: ans=%h cout=%b V=%b want 00000000 0 0", bus.ans, bus.cout, bus.V);
    end
`ifdef ADDSUB_ZERO_FLAG_EN
    n_checks++;
    if (bus.Z !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_z: Z=%b want 0", bus.Z);
    end
`endif
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ans !== 32'h0 || bus.cout !== 1'b0 || bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: ans=%h cout=%b V=%b want 00000000 0 0", bus.ans, bus.cout, bus.V);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_overflow;
    @(negedge clk);
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ans !== 32'h8000_0000 || bus.cout !== 1'b0 || bus.V !== 1'b1) begin
      n_fail++;
      $display("FAIL add_pos_overflow: ans=%h cout=%b V=%b want 80000000 0 1", bus.ans, bus.cout, bus.V);
    end
  endtask

  task automatic test_add_wrap;
    @(negedge clk);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ans !== 32'h0000_0000 || bus.cout !== 1'b1 || bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL add_wrap_zero: ans=%h cout=%b V=%b want 00000000 1 0", bus.ans, bus.cout, bus.V);
    end
`ifdef ADDSUB_ZERO_FLAG_EN
    n_checks++;
    if (bus.Z !== 1'b1) begin
      n_fail++;
      $display("FAIL add_wrap_z: Z=%b want 1", bus.Z);
    end
`endif
  endtask

  task automatic test_sub_borrow;
    @(negedge clk);
    drive(32'h0000_0003, 32'h0000_0005, 1'b1);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ans !== 32'hFFFF_FFFE || bus.cout !== 1'b0 || bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: ans=%h cout=%b V=%b want fffffffe 0 0", bus.ans, bus.cout, bus.V);
    end
`ifdef ADDSUB_ZERO_FLAG_EN
    n_checks++;
    if (bus.Z !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow_z: Z=%b want 0", bus.Z);
    end
`endif
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(32'h8000_0000, 32'h0000_0001, 1'b1);
    @(posedge clk);
    #1;
    drive(32'h0000_0005, 32'h0000_0003, 1'b1);
    n_checks++;
    if (bus.ans !== 32'h7FFF_FFFF || bus.cout !== 1'b1 || bus.V !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_sub_overflow: ans=%h cout=%b V=%b want 7fffffff 1 1", bus.ans, bus.cout, bus.V);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.ans !== 32'h0000_0002 || bus.cout !== 1'b1 || bus.V !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_sub_small: ans=%h cout=%b V=%b want 00000002 1 0", bus.ans, bus.cout, bus.V);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, b_eff;
    logic        s;
    logic [32:0] full;
    addsub_res_t exp_res;
    int          nerr;
    nerr    = 0;
    exp_res = '0;
    for (int i = 0; i <= 5000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (bus.ans !== exp_res.sum || bus.cout !== exp_res.cout || bus.V !== exp_res.v) begin
          n_fail++;
          nerr++;
          if (nerr <= 10)
            $display("FAIL random_%0d: ans=%h cout=%b V=%b want %h %b %b", i - 1,
                     bus.ans, bus.cout, bus.V, exp_res.sum, exp_res.cout, exp_res.v);
        end
      end
      if (i < 5000) begin
        a = $urandom;
        b = $urandom;
        s = 1'($urandom_range(1, 0));
        if (i % 7 == 0) a = {a[31], 31'h7FFF_FFFF};
        drive(a, b, s);
        b_eff        = s ? ~b : b;
        full         = {1'b0, a} + {1'b0, b_eff} + {32'h0, s};
        exp_res.sum  = full[31:0];
        exp_res.cout = full[32];
        exp_res.v    = (a[31] == b_eff[31]) && (full[31] != a[31]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    test_reset();
    test_add_overflow();
    test_add_wrap();
    test_sub_borrow();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
